// File: rtl/sparse_pe_acc.sv
// sparse_pe_acc: gathers up to MAC_DIM sparse operand pairs per beat, accumulates them per node
// and emits a saturated, tagged node sum through a valid/ready output register.
module sparse_pe_acc #(
   parameter int MAC_DIM      = 5,
   parameter int FEAT_WIDTH   = 8,
   parameter int WGT_WIDTH    = 8,
   parameter int SPAD_WIDTH   = 64,
   parameter int ADDR_WIDTH   = $clog2(SPAD_WIDTH),
   parameter int NNZ_WIDTH    = $clog2(MAC_DIM + 1),
   parameter int TAG_WIDTH    = 12,
   parameter int PE_OUT_WIDTH = 24
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [FEAT_WIDTH*SPAD_WIDTH-1:0] feature_in,
   input  logic [WGT_WIDTH*SPAD_WIDTH-1:0]  weight_in,
   input  logic [ADDR_WIDTH*MAC_DIM-1:0]    non_zero_add_in,
   input  logic [NNZ_WIDTH-1:0]             non_zero_num,
   input  logic                           first,
   input  logic                           last,
   input  logic [TAG_WIDTH-1:0]           tag_in,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic signed [PE_OUT_WIDTH-1:0] sum_out,
   output logic [TAG_WIDTH-1:0]           tag_out,
   output logic                           sat_out
);
   localparam int PW = FEAT_WIDTH + WGT_WIDTH;
   localparam int BW = PW + $clog2(MAC_DIM);
   localparam int AW = PE_OUT_WIDTH + 1;
   localparam logic signed [PE_OUT_WIDTH-1:0] ACC_MAX = {1'b0, {(PE_OUT_WIDTH-1){1'b1}}};
   localparam logic signed [PE_OUT_WIDTH-1:0] ACC_MIN = {1'b1, {(PE_OUT_WIDTH-1){1'b0}}};

   if (PE_OUT_WIDTH < BW) begin : g_width_check
      $error("sparse_pe_acc: PE_OUT_WIDTH cannot hold an exact beat sum");
   end

   logic signed [FEAT_WIDTH-1:0] feat [SPAD_WIDTH];
   logic signed [WGT_WIDTH-1:0]  wgt  [SPAD_WIDTH];
   logic signed [PW-1:0]         lane_prod [MAC_DIM];
   logic signed [PW-1:0]         s1_prod [MAC_DIM];
   logic                         s1_valid, s1_first, s1_last;
   logic [TAG_WIDTH-1:0]         s1_tag;
   logic signed [PE_OUT_WIDTH-1:0] acc, acc_base, acc_next;
   logic signed [BW-1:0]         beat_sum;
   logic signed [AW-1:0]         acc_wide;
   logic                         sat_acc, clamp_now, sat_now, stall;

   for (genvar i = 0; i < SPAD_WIDTH; i++) begin : g_spad
      assign feat[i] = feature_in[i*FEAT_WIDTH +: FEAT_WIDTH];
      assign wgt[i]  = weight_in[i*WGT_WIDTH +: WGT_WIDTH];
   end

   // lanes at or beyond the non-zero count, or pointing past the scratchpad, contribute 0
   for (genvar k = 0; k < MAC_DIM; k++) begin : g_lane
      logic [ADDR_WIDTH-1:0] addr;
      assign addr = non_zero_add_in[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign lane_prod[k] = (int'(non_zero_num) > k && int'(addr) < SPAD_WIDTH)
         ? PW'(feat[addr]) * PW'(wgt[addr]) : '0;
   end

   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;

   always_comb begin
      beat_sum = '0;
      for (int j = 0; j < MAC_DIM; j++) beat_sum = beat_sum + BW'(s1_prod[j]);
      acc_base  = s1_first ? '0 : acc;
      acc_wide  = AW'(acc_base) + AW'(beat_sum);
      clamp_now = acc_wide[AW-1] ^ acc_wide[AW-2];
      acc_next  = clamp_now ? (acc_wide[AW-1] ? ACC_MIN : ACC_MAX) : acc_wide[PE_OUT_WIDTH-1:0];
      sat_now   = (~s1_first & sat_acc) | clamp_now;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         s1_first  <= 1'b0;
         s1_last   <= 1'b0;
         s1_tag    <= '0;
         s1_prod   <= '{default: '0};
         acc       <= '0;
         sat_acc   <= 1'b0;
         out_valid <= 1'b0;
         sum_out   <= '0;
         tag_out   <= '0;
         sat_out   <= 1'b0;
      end else if (!stall) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_prod  <= lane_prod;
            s1_first <= first;
            s1_last  <= last;
            s1_tag   <= tag_in;
         end
         out_valid <= s1_valid & s1_last;
         if (s1_valid) begin
            acc     <= s1_last ? '0 : acc_next;
            sat_acc <= ~s1_last & sat_now;
            if (s1_last) begin
               sum_out <= acc_next;
               tag_out <= s1_tag;
               sat_out <= sat_now;
            end
         end
      end
   end
endmodule

// File: tb/tb_sparse_pe_acc.sv
// tb_sparse_pe_acc: table vectors, directed multi-cycle sequences and a randomized run
// checked against a node-level arithmetic scoreboard.
module tb_sparse_pe_acc;
   localparam int MAC = 5, FW = 8, WW = 8, SP = 64, AD = 6, NW = 3, TW = 12, POW = 20;
   localparam longint SMAX = (longint'(1) << (POW - 1)) - 1;
   localparam longint SMIN = -(longint'(1) << (POW - 1));

   logic clk, reset, in_valid, in_ready, first, last, out_valid, out_ready, sat_out;
   logic [FW*SP-1:0] feature_in;
   logic [WW*SP-1:0] weight_in;
   logic [AD*MAC-1:0] non_zero_add_in;
   logic [NW-1:0] non_zero_num;
   logic [TW-1:0] tag_in, tag_out;
   logic signed [POW-1:0] sum_out;

   sparse_pe_acc #(.MAC_DIM(MAC), .FEAT_WIDTH(FW), .WGT_WIDTH(WW), .SPAD_WIDTH(SP),
                   .TAG_WIDTH(TW), .PE_OUT_WIDTH(POW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .feature_in(feature_in), .weight_in(weight_in), .non_zero_add_in(non_zero_add_in),
      .non_zero_num(non_zero_num), .first(first), .last(last), .tag_in(tag_in),
      .out_valid(out_valid), .out_ready(out_ready), .sum_out(sum_out), .tag_out(tag_out),
      .sat_out(sat_out));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { int a[MAC]; int f[MAC]; int w[MAC]; int nnz; int tag; longint sum; } vec_t;
   typedef struct { longint sum; int tag; bit sat; } res_t;

   vec_t tbl[7];
   res_t exp_q[$];
   int fv[SP], wv[SP], av[MAC];
   int n_vec = 0, n_err = 0;
   longint m_acc, prev_sum;
   bit m_sat, prev_stall, prev_sat, dir;
   int prev_tag;

   task automatic chk(input string name, input longint act, input longint req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_spad();
      for (int i = 0; i < SP; i++) begin
         fv[i] = 0;
         wv[i] = 0;
      end
      for (int k = 0; k < MAC; k++) av[k] = 0;
   endtask

   task automatic load_bus();
      for (int i = 0; i < SP; i++) begin
         feature_in[i*FW +: FW] = FW'(fv[i]);
         weight_in[i*WW +: WW]  = WW'(wv[i]);
      end
      for (int k = 0; k < MAC; k++) non_zero_add_in[k*AD +: AD] = AD'(av[k]);
   endtask

   task automatic set_beat(input bit f, input bit l, input int t, input int n);
      first = f;
      last = l;
      tag_in = TW'(t);
      non_zero_num = NW'(n);
      load_bus();
      in_valid = 1'b1;
   endtask

   task automatic chk_out(input string name, input longint s, input int t, input bit sat);
      chk({name, "_valid"}, out_valid, 1);
      chk({name, "_sum"}, sum_out, s);
      chk({name, "_tag"}, tag_out, t);
      chk({name, "_sat"}, sat_out, sat);
   endtask

   // reference: sum of active-lane products, accumulated per node and clamped to the output range
   function automatic longint beat_val(input int n);
      longint s = 0;
      for (int k = 0; k < MAC && k < n; k++) s += longint'(fv[av[k]]) * wv[av[k]];
      return s;
   endfunction

   task automatic model_accept(input bit f, input bit l, input int t, input int n);
      longint v;
      bit s;
      v = (f ? 0 : m_acc) + beat_val(n);
      s = f ? 1'b0 : m_sat;
      if (v > SMAX) begin
         v = SMAX;
         s = 1'b1;
      end else if (v < SMIN) begin
         v = SMIN;
         s = 1'b1;
      end
      if (l) begin
         exp_q.push_back('{v, t, s});
         m_acc = 0;
         m_sat = 1'b0;
      end else begin
         m_acc = v;
         m_sat = s;
      end
   endtask

   task automatic pop_check(input string name);
      res_t e;
      if (exp_q.size() == 0) begin
         chk({name, "_extra_output"}, out_valid, 0);
      end else begin
         e = exp_q.pop_front();
         chk({name, "_sum"}, sum_out, e.sum);
         chk({name, "_tag"}, tag_out, e.tag);
         chk({name, "_sat"}, sat_out, e.sat);
      end
   endtask

   initial begin
      tbl[0] = '{'{3, 7, 0, 1, 2}, '{2, -4, 9, 9, 9}, '{3, 5, 9, 9, 9}, 2, 9, -14};
      tbl[1] = '{'{10, 11, 12, 13, 14}, '{5, 5, 5, 5, 5}, '{6, 6, 6, 6, 6}, 0, 1, 0};
      tbl[2] = '{'{10, 11, 12, 13, 14}, '{5, 5, 5, 5, 5}, '{6, 6, 6, 6, 6}, 7, 2, 150};
      tbl[3] = '{'{63, 20, 21, 22, 23}, '{-128, 127, 1, -1, 0}, '{-128, 127, -1, -1, 50}, 5, 4095, 32513};
      tbl[4] = '{'{5, 6, 8, 9, 60}, '{7, 1, 1, 1, 1}, '{-8, 1, 1, 1, 1}, 1, 77, -56};
      tbl[5] = '{'{30, 31, 32, 33, 34}, '{-128, -128, -128, -128, -128}, '{127, 127, 127, 127, 127}, 5, 100, -81280};
      tbl[6] = '{'{40, 41, 42, 43, 44}, '{-128, -128, -128, -128, -128}, '{-128, -128, -128, -128, -128}, 5, 3, 81920};

      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      first = 1'b0;
      last = 1'b0;
      tag_in = '0;
      non_zero_num = '0;
      clear_spad();
      load_bus();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum_out, 0);
      chk("rst_tag", tag_out, 0);
      chk("rst_sat", sat_out, 0);
      chk("rst_in_ready", in_ready, 1);
      out_ready = 1'b1;

      foreach (tbl[v]) begin
         clear_spad();
         for (int k = 0; k < MAC; k++) begin
            av[k] = tbl[v].a[k];
            fv[tbl[v].a[k]] = tbl[v].f[k];
            wv[tbl[v].a[k]] = tbl[v].w[k];
         end
         set_beat(1, 1, tbl[v].tag, tbl[v].nnz);
         chk($sformatf("tbl%0d_in_ready", v), in_ready, 1);
         tick();
         in_valid = 1'b0;
         chk($sformatf("tbl%0d_early", v), out_valid, 0);
         tick();
         chk_out($sformatf("tbl%0d", v), tbl[v].sum, tbl[v].tag, 0);
      end

      // multi-beat node, then back-to-back single-beat nodes (second without first)
      clear_spad();
      fv[0] = 10;
      wv[0] = 10;
      set_beat(1, 0, 0, 1);
      tick();
      set_beat(0, 0, 0, 1);
      tick();
      set_beat(0, 1, 42, 1);
      tick();
      in_valid = 1'b0;
      chk("multi_early", out_valid, 0);
      tick();
      chk_out("multi", 300, 42, 0);
      set_beat(1, 1, 43, 1);
      tick();
      set_beat(0, 1, 44, 1);
      tick();
      in_valid = 1'b0;
      chk_out("b2b_a", 100, 43, 0);
      tick();
      chk_out("b2b_b", 100, 44, 0);
      tick();
      chk("b2b_idle", out_valid, 0);

      // positive saturation, then a clean node
      clear_spad();
      for (int k = 0; k < MAC; k++) begin
         av[k] = k;
         fv[k] = 127;
         wv[k] = 127;
      end
      for (int b = 0; b < 7; b++) begin
         set_beat(b == 0, b == 6, 5, 5);
         tick();
      end
      in_valid = 1'b0;
      tick();
      chk_out("sat_pos", 524287, 5, 1);
      set_beat(1, 1, 6, 5);
      tick();
      in_valid = 1'b0;
      tick();
      chk_out("sat_next", 80645, 6, 0);

      // negative clamp mid-node stays flagged after the sum comes back into range
      for (int k = 0; k < MAC; k++) begin
         fv[k] = -128;
         fv[k+5] = 127;
         wv[k+5] = 127;
      end
      for (int b = 0; b < 8; b++) begin
         for (int k = 0; k < MAC; k++) av[k] = (b == 7) ? k + 5 : k;
         set_beat(b == 0, b == 7, 8, 5);
         tick();
      end
      in_valid = 1'b0;
      tick();
      chk_out("sat_sticky", -443643, 8, 1);

      // asynchronous reset between a non-last and a last beat
      clear_spad();
      fv[0] = 10;
      wv[0] = 10;
      set_beat(1, 0, 0, 1);
      tick();
      set_beat(0, 0, 0, 1);
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      #3 reset = 1'b1;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_sum", sum_out, 0);
      chk("arst_tag", tag_out, 0);
      chk("arst_sat", sat_out, 0);
      @(posedge clk);
      #2 reset = 1'b0;
      tick();
      chk("arst_in_ready", in_ready, 1);
      fv[0] = 2;
      wv[0] = 3;
      set_beat(0, 1, 11, 1);
      tick();
      set_beat(1, 1, 12, 1);
      tick();
      in_valid = 1'b0;
      chk_out("arst_cont", 6, 11, 0);
      tick();
      chk_out("arst_first", 6, 12, 0);

      // backpressure: result held, pipeline frozen, then drained in order
      clear_spad();
      fv[0] = 10;
      wv[0] = 10;
      fv[1] = 2;
      wv[1] = 3;
      av[1] = 1;
      tick();
      out_ready = 1'b0;
      set_beat(1, 1, 1, 1);
      tick();
      set_beat(1, 1, 2, 2);
      chk("bp_early", out_valid, 0);
      tick();
      set_beat(1, 1, 3, 0);
      chk_out("bp_held0", 100, 1, 0);
      chk("bp_in_ready", in_ready, 0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk_out($sformatf("bp_held%0d", c + 1), 100, 1, 0);
         chk($sformatf("bp_in_ready%0d", c + 1), in_ready, 0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk_out("bp_second", 106, 2, 0);
      tick();
      chk_out("bp_third", 0, 3, 0);
      tick();
      chk("bp_idle", out_valid, 0);

      // randomized traffic against the scoreboard
      reset = 1'b1;
      #2 reset = 1'b0;
      m_acc = 0;
      m_sat = 1'b0;
      prev_stall = 1'b0;
      dir = 1'b0;
      tick();
      for (int c = 0; c < 3000; c++) begin
         bit rf, rl, ext;
         int rt, rn;
         if (prev_stall) begin
            chk("rnd_hold_valid", out_valid, 1);
            chk("rnd_hold_sum", sum_out, prev_sum);
            chk("rnd_hold_tag", tag_out, prev_tag);
            chk("rnd_hold_sat", sat_out, prev_sat);
         end
         rf = $urandom_range(0, 3) == 0;
         rl = $urandom_range(0, 5) == 0;
         rt = int'($urandom_range(0, 4095));
         rn = int'($urandom_range(0, 7));
         if (rf) dir = 1'($urandom_range(0, 1));
         ext = $urandom_range(0, 2) != 0;
         for (int i = 0; i < SP; i++) begin
            fv[i] = ext ? 127 : int'($urandom_range(0, 255)) - 128;
            wv[i] = ext ? (dir ? 127 : -128) : int'($urandom_range(0, 255)) - 128;
         end
         for (int k = 0; k < MAC; k++) av[k] = int'($urandom_range(0, SP - 1));
         set_beat(rf, rl, rt, rn);
         in_valid = $urandom_range(0, 3) != 0;
         out_ready = $urandom_range(0, 3) != 0;
         #1;
         chk("rnd_in_ready", in_ready, !(out_valid && !out_ready));
         if (out_valid && out_ready) pop_check("rnd");
         if (in_valid && in_ready) model_accept(rf, rl, rt, rn);
         prev_stall = out_valid && !out_ready;
         prev_sum = sum_out;
         prev_tag = int'(tag_out);
         prev_sat = sat_out;
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
         if (out_valid) pop_check("drain");
         tick();
      end
      chk("drain_left", exp_q.size(), 0);
      chk("drain_idle", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
